// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory port arbiter.
// State encodings, default read latency and requester ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN0  = 2'b01,
        OWN1  = 2'b10,
        DRAIN = 2'b11
    } arb_state_e;

    localparam int RD_LAT_DEF = 2;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag pipe: carries {valid, owner} of each accepted read
// for RD_LAT cycles so the returning data can be steered.
module rd_tag_pipe #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid,
    input  logic push_owner,
    output logic out_valid,
    output logic out_owner,
    output logic pending
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] valid_d;
    logic [RD_LAT-1:0] owner_q;
    logic [RD_LAT-1:0] owner_d;

    always_comb begin
        valid_d    = valid_q;
        owner_d    = owner_q;
        valid_d[0] = push_valid;
        owner_d[0] = push_owner;
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            owner_d[i] = owner_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_owner = owner_q[RD_LAT-1];
    assign pending   = |valid_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the four-bank memory port to the I-cache or D-cache for whole
// miss sequences and steers read returns back to the owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              rd_0,
    input  logic              rd_1,
    input  logic              wr_0,
    input  logic              wr_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic [ADDR_W-1:0] Addr_mem,
    output logic [DATA_W-1:0] DataIn_mem,
    output logic              wr_mem,
    output logic              rd_mem,
    input  logic [DATA_W-1:0] DataOut_mem,
    output logic              busy,
    output logic              err
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_winner_q;
    logic       last_winner_d;
    logic       err_q;
    logic       err_d;

    logic act_0;
    logic act_1;
    logic tag_valid;
    logic tag_owner;
    logic tag_pending;
    logic proto_bad;

    assign gnt_0 = (state_q == OWN0);
    assign gnt_1 = (state_q == OWN1);
    assign busy  = (state_q != IDLE);
    assign err   = err_q;

    // A command is live only while its owner still holds req.
    assign act_0 = gnt_0 && req_0;
    assign act_1 = gnt_1 && req_1;

    always_comb begin
        Addr_mem   = '0;
        DataIn_mem = '0;
        if (act_0) begin
            Addr_mem   = addr_0;
            DataIn_mem = wdata_0;
        end else if (act_1) begin
            Addr_mem   = addr_1;
            DataIn_mem = wdata_1;
        end
    end

    assign wr_mem = (act_0 && wr_0) || (act_1 && wr_1);
    assign rd_mem = (act_0 && rd_0 && !wr_0) || (act_1 && rd_1 && !wr_1);

    assign proto_bad = ((rd_0 || wr_0) && !gnt_0)
                    || ((rd_1 || wr_1) && !gnt_1)
                    || (rd_0 && wr_0)
                    || (rd_1 && wr_1);

    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        err_d         = err_q || proto_bad;
        unique case (state_q)
            IDLE: begin
                if (req_0 && req_1) begin
                    last_winner_d = !last_winner_q;
                    state_d       = last_winner_q ? OWN0 : OWN1;
                end else if (req_0) begin
                    last_winner_d = REQ_I;
                    state_d       = OWN0;
                end else if (req_1) begin
                    last_winner_d = REQ_D;
                    state_d       = OWN1;
                end
            end
            OWN0: begin
                if (!req_0) state_d = DRAIN;
            end
            OWN1: begin
                if (!req_1) state_d = DRAIN;
            end
            DRAIN: begin
                if (!tag_pending) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_winner_q <= REQ_D;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            err_q         <= err_d;
        end
    end

    rd_tag_pipe #(
        .RD_LAT(RD_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst),
        .push_valid(rd_mem),
        .push_owner(act_1 ? REQ_D : REQ_I),
        .out_valid (tag_valid),
        .out_owner (tag_owner),
        .pending   (tag_pending)
    );

    assign rvalid_0 = tag_valid && (tag_owner == REQ_I);
    assign rvalid_1 = tag_valid && (tag_owner == REQ_D);
    assign rdata_0  = DataOut_mem;
    assign rdata_1  = DataOut_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a read-return scoreboard
// and a latency-matched memory model.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_0, req_1, rd_0, rd_1, wr_0, wr_1;
    logic [15:0] addr_0, addr_1, wdata_0, wdata_1;
    logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [15:0] rdata_0, rdata_1, Addr_mem, DataIn_mem, DataOut_mem;
    logic        wr_mem, rd_mem, busy, err;

    int n_chk;
    int n_fail;
    int rv0_cnt;
    int rv1_cnt;
    logic [16:0] sb[$];
    logic [15:0] mpipe[LAT];

    mem_port_arbiter #(
        .ADDR_W(16),
        .DATA_W(16),
        .RD_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .req_1(req_1),
        .rd_0(rd_0), .rd_1(rd_1),
        .wr_0(wr_0), .wr_1(wr_1),
        .addr_0(addr_0), .addr_1(addr_1),
        .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1),
        .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .Addr_mem(Addr_mem), .DataIn_mem(DataIn_mem),
        .wr_mem(wr_mem), .rd_mem(rd_mem),
        .DataOut_mem(DataOut_mem),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // memory: read data appears LAT cycles after rd_mem is accepted
    always @(posedge clk) begin
        mpipe[0] <= rd_mem ? mem_val(Addr_mem) : 16'h0000;
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign DataOut_mem = mpipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && (rvalid_0 || rvalid_1)) begin
            logic [16:0] e;
            if (rvalid_0) rv0_cnt++;
            if (rvalid_1) rv1_cnt++;
            chk("rv_onehot", {31'd0, rvalid_0 && rvalid_1}, 0);
            chk("rv_expected", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rv_owner", {31'd0, rvalid_1}, {31'd0, e[16]});
                chk("rdata_0", {16'd0, rdata_0}, {16'd0, e[15:0]});
                chk("rdata_1", {16'd0, rdata_1}, {16'd0, e[15:0]});
            end
        end
    end

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        chk(tag, {31'd0, busy}, 0);
    endtask

    task automatic wait_gnt(input string tag, input int which);
        logic g;
        g = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            g = (which == 0) ? gnt_0 : gnt_1;
            if (g) break;
        end
        chk(tag, {31'd0, g}, 1);
    endtask

    initial begin
        int base0, base1, ncyc;
        logic seen;
        n_chk = 0; n_fail = 0; rv0_cnt = 0; rv1_cnt = 0;
        req_0 = 0; req_1 = 0; rd_0 = 0; rd_1 = 0; wr_0 = 0; wr_1 = 0;
        addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_gnt", {30'd0, gnt_1, gnt_0}, 0);
        chk("rst_cmd", {30'd0, rd_mem, wr_mem}, 0);
        chk("rst_busy_err", {30'd0, busy, err}, 0);
        chk("rst_rvalid", {30'd0, rvalid_1, rvalid_0}, 0);
        chk("rst_addr_data", {Addr_mem, DataIn_mem}, 0);
        rst = 1'b1;

        // single read by requester 1
        @(negedge clk);
        req_1 = 1;
        #1 chk("t1_gnt_lat", {31'd0, gnt_1}, 0);
        @(negedge clk);
        #1 chk("t1_gnt", {30'd0, gnt_1, gnt_0}, 2'b10);
        chk("t1_busy", {31'd0, busy}, 1);
        rd_1 = 1; addr_1 = 16'h1238;
        sb.push_back({1'b1, mem_val(16'h1238)});
        #1 chk("t1_rd_mem", {31'd0, rd_mem}, 1);
        chk("t1_addr", {16'd0, Addr_mem}, 16'h1238);
        @(negedge clk);
        rd_1 = 0; req_1 = 0;
        #1 chk("t1_rv_early", {31'd0, rvalid_1}, 0);
        @(negedge clk);
        #1 chk("t1_rvalid", {30'd0, rvalid_1, rvalid_0}, 2'b10);
        chk("t1_drain", {30'd0, busy, gnt_1}, 2'b10);
        wait_idle("t1_idle");
        chk("t1_err", {31'd0, err}, 0);

        // tie alternation
        req_0 = 1; req_1 = 1;
        @(negedge clk);
        #1 chk("t2_tie1", {30'd0, gnt_1, gnt_0}, 2'b01);
        req_0 = 0;
        @(negedge clk);
        #1 chk("t2_drain", {29'd0, busy, gnt_1, gnt_0}, 3'b100);
        @(negedge clk);
        #1 chk("t2_idle", {29'd0, busy, gnt_1, gnt_0}, 3'b000);
        @(negedge clk);
        #1 chk("t2_gnt1", {30'd0, gnt_1, gnt_0}, 2'b10);
        req_1 = 0;
        wait_idle("t2_idle2");
        req_0 = 1; req_1 = 1;
        @(negedge clk);
        #1 chk("t2_tie2", {30'd0, gnt_1, gnt_0}, 2'b01);
        req_0 = 0; req_1 = 0;
        wait_idle("t2_idle3");

        // four back-to-back reads then release with reads in flight
        req_0 = 1;
        wait_gnt("t3_gnt0", 0);
        req_1 = 1;
        base0 = rv0_cnt; base1 = rv1_cnt;
        for (int i = 0; i < 4; i++) begin
            rd_0 = 1; addr_0 = 16'(2 * i);
            sb.push_back({1'b0, mem_val(16'(2 * i))});
            #1 chk("t3_rd_addr", {15'd0, rd_mem, Addr_mem}, {15'd0, 1'b1, 16'(2 * i)});
            @(negedge clk);
        end
        rd_0 = 0; req_0 = 0;
        ncyc = 0; seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            ncyc++;
            if (gnt_1) begin
                seen = 1;
                break;
            end
        end
        chk("t3_gnt1_seen", {31'd0, seen}, 1);
        chk("t3_gnt1_wait", ncyc, 4);
        chk("t3_rv0_count", rv0_cnt - base0, 4);
        chk("t3_rv1_none", rv1_cnt - base1, 0);
        req_1 = 0;
        wait_idle("t3_idle");
        chk("t3_err", {31'd0, err}, 0);

        // non-owner write is blocked and flags err
        req_0 = 1;
        wait_gnt("t4_gnt0", 0);
        wr_0 = 1; addr_0 = 16'h0010; wdata_0 = 16'h1111;
        wr_1 = 1; addr_1 = 16'h00A0; wdata_1 = 16'h9999;
        #1 chk("t4_wr_own", {15'd0, wr_mem, Addr_mem}, {15'd0, 1'b1, 16'h0010});
        chk("t4_wdata", {16'd0, DataIn_mem}, 16'h1111);
        @(negedge clk);
        wr_0 = 0;
        #1 chk("t4_err", {31'd0, err}, 1);
        chk("t4_wr_blk", {15'd0, wr_mem, Addr_mem}, {15'd0, 1'b0, 16'h0010});
        @(negedge clk);
        wr_1 = 0; req_0 = 0;
        wait_idle("t4_idle");
        chk("t4_err_sticky", {31'd0, err}, 1);

        // reset with a read in flight
        req_0 = 1;
        wait_gnt("t5_gnt0", 0);
        rd_0 = 1; addr_0 = 16'h0100;
        @(negedge clk);
        rd_0 = 0;
        #2 rst = 0;
        sb.delete();
        #1;
        chk("t5_rst_gnt", {29'd0, busy, gnt_1, gnt_0}, 0);
        chk("t5_rst_err", {31'd0, err}, 0);
        chk("t5_rst_mem", {14'd0, rd_mem, wr_mem, Addr_mem}, 0);
        chk("t5_rst_rv", {30'd0, rvalid_1, rvalid_0}, 0);
        req_0 = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 chk("t5_no_spur", {30'd0, rvalid_1, rvalid_0}, 0);
        end
        req_0 = 1; req_1 = 1;
        @(negedge clk);
        #1 chk("t5_tie", {30'd0, gnt_1, gnt_0}, 2'b01);
        req_0 = 0; req_1 = 0;
        wait_idle("t5_idle");

        // write burst by requester 1
        req_1 = 1;
        wait_gnt("t6_gnt1", 1);
        base0 = rv0_cnt; base1 = rv1_cnt;
        for (int i = 0; i < 4; i++) begin
            wr_1 = 1;
            addr_1 = 16'h4000 + 16'(2 * i);
            wdata_1 = 16'hAAAA + 16'(i * 16'h1111);
            #1 chk("t6_wr", {30'd0, wr_mem, rd_mem}, 2'b10);
            chk("t6_addr_data", {Addr_mem, DataIn_mem},
                {16'h4000 + 16'(2 * i), 16'hAAAA + 16'(i * 16'h1111)});
            @(negedge clk);
        end
        wr_1 = 0; req_1 = 0;
        wait_idle("t6_idle");
        repeat (LAT + 1) @(negedge clk);
        chk("t6_no_rv", (rv0_cnt - base0) + (rv1_cnt - base1), 0);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single four-bank main-memory port between two cache controllers: requester 0 is the instruction cache, requester 1 is the data cache.
- Grants whole miss sequences (write-back plus fill bursts) to one requester at a time.
- Multiplexes that requester's rd/wr/address/data onto the memory and steers returning read data back, tagged with a valid strobe.
- Sits between the cache controllers and the four-bank memory in the top-level memory system.

Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- RD_LAT, 2, cycles from rd_mem accepted to DataOut_mem valid (1..4)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- req_0, req_1  in  1  requester holds high for its entire memory sequence
- rd_0, rd_1  in  1  read command, honoured only while owning the port
- wr_0, wr_1  in  1  write command, honoured only while owning the port
- addr_0, addr_1  in  ADDR_W  command address
- wdata_0, wdata_1  in  DATA_W  write data
- gnt_0, gnt_1  out  1  registered grant
- rdata_0, rdata_1  out  DATA_W  read data (DataOut_mem broadcast)
- rvalid_0, rvalid_1  out  1  read data valid for that requester
- Addr_mem  out  ADDR_W  memory address
- DataIn_mem  out  DATA_W  memory write data
- wr_mem, rd_mem  out  1  memory commands
- DataOut_mem  in  DATA_W  memory read data
- busy  out  1  state is not IDLE
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, async):
  - State = IDLE.
  - gnt_*, rvalid_*, wr_mem, rd_mem, busy and err all 0; Addr_mem and DataIn_mem 0.
  - last_winner = 1, so requester 0 wins the first tie.
  - Tag pipe cleared; any in-flight read is discarded with no rvalid.
- States: IDLE, OWN0, OWN1, DRAIN.
- IDLE:
  - No req: stay.
  - Exactly one req: go to OWNx.
  - Both req: go to the requester other than last_winner.
  - Grant appears the cycle after req is first sampled (1-cycle arbitration latency). last_winner updates on entry to OWNx.
- OWNx:
  - gnt_x=1, gnt of the other requester = 0.
  - rd_mem=rd_x, wr_mem=wr_x, Addr_mem=addr_x, DataIn_mem=wdata_x, all combinational pass-through.
  - Stay while req_x=1. When req_x=0, go to DRAIN; no command from x is accepted in that cycle.
- DRAIN:
  - gnt_*=0, memory commands forced 0.
  - Wait until the tag pipe holds no pending read, then go to IDLE.
  - If the pipe is already empty, DRAIN lasts exactly 1 cycle.
  - No re-grant happens directly from DRAIN, so round-robin holds: if the other requester is waiting, it wins the next arbitration.
- Non-owner commands:
  - Any rd_x or wr_x while gnt_x=0 is blocked: it never reaches memory.
  - It sets err=1; err stays set until reset.
- rd_x and wr_x both high in the same cycle: treated as a protocol error; err=1; wr takes precedence on the memory port.
- Read return:
  - Each accepted rd_mem pushes owner id + valid into an RD_LAT-deep shift register.
  - At the pipe output, rvalid_<owner>=1 for exactly one cycle; rdata_0 = rdata_1 = DataOut_mem at all times.
  - Back-to-back reads are supported, one per cycle.
- Writes: no return strobe; the memory accepts a write in the cycle it is presented.
- Owner drops req with reads in flight: those reads still complete to that owner during DRAIN.
- No state is ever unreachable. Any illegal encoding goes to IDLE and sets err=1.

Decomposition:
- Shared package mem_arb_pkg holds:
  - 2-bit state encodings IDLE=00, OWN0=01, OWN1=10, DRAIN=11
  - default RD_LAT
  - requester id constants REQ_I=0, REQ_D=1
- One natural sub-module: rd_tag_pipe.
  - Parameterised RD_LAT shift register of {valid, owner}.
  - Exposes out_valid, out_owner, and pending (OR of all stages).
- State and last_winner use the team's reg_16-style flops with async active-low clear.

Test Plan:
- Reset, then req_1=1 at cycle 0 → gnt_1=1 at cycle 1; rd_1 with addr_1=0x1238 → rd_mem=1, Addr_mem=0x1238; rvalid_1=1 at cycle 1+RD_LAT carrying DataOut_mem.
- req_0=req_1=1 together after reset → gnt_0 first. Requester 0 releases → DRAIN 1 cycle → IDLE → gnt_1. Repeat the tie → gnt_0 again, i.e. alternation.
- Owner 0 issues 4 back-to-back reads (0x0000, 0x0002, 0x0004, 0x0006), then drops req on the next cycle → DRAIN holds until the 4th rvalid_0; rvalid_1 never asserts; gnt_1 waits.
- While gnt_0=1, requester 1 asserts wr_1 with addr_1=0x00A0 → wr_mem follows only wr_0, memory never sees 0x00A0, err=1 and stays set.
- Reset asserted mid-burst, 1 read in flight → all outputs 0 immediately (async); after release, no spurious rvalid; the first tie goes to requester 0.
- Write burst by requester 1: wr_1 with addresses 0x4000/0x4002/0x4004/0x4006 and data 0xAAAA..0xDDDD → same values on Addr_mem/DataIn_mem in the same cycles; no rvalid asserted.
